// File: rtl/pulse_transmitter_program_sequencer.sv
// Symbol program sequencer for the pulse transmitter: walks 2-bit symbols from start to end pc,
// prefetching the next symbol during the timer countdown. Loop support under PULSE_SEQ_LOOP_EN.
module pulse_transmitter_program_sequencer #(
  parameter int NUM_WORDS = 4,
  parameter int PC_W      = $clog2(NUM_WORDS*16)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   cfg_start_pc,
  input  logic [PC_W-1:0]   cfg_end_pc,
  input  logic [7:0]        cfg_loop_count,
  input  logic [31:0]       cfg_durations,
  input  logic              cfg_idle_level,
  output logic [PC_W-5:0]   mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tmr_en,
  output logic              tmr_load,
  output logic [7:0]        tmr_duration,
  input  logic              tmr_done,
  output logic              level_out,
  output logic              busy,
  output logic              loop_pulse,
  output logic              done_irq,
  input  logic              irq_clear
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic            start_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            last_q, last_d;
  logic            final_q, final_d;
  logic            pf_valid_q, pf_valid_d;
  logic            pf_level_q, pf_level_d;
  logic            pf_last_q, pf_last_d;
  logic [7:0]      pf_dur_q, pf_dur_d;
  logic            level_q, level_d;
  logic [7:0]      dur_q, dur_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;
  logic            wrap;

  logic [1:0]      cur_sym;
  logic [7:0]      cur_dur;
  logic            cur_last;

  assign cur_sym  = mem_rdata[{pc_q[3:0], 1'b0} +: 2];
  assign cur_dur  = cfg_durations[{cur_sym, 3'b000} +: 8];
  assign cur_last = (pc_q == cfg_end_pc);

`ifdef PULSE_SEQ_LOOP_EN
  logic [7:0] loops_left_q, loops_left_d;
  // loops_left of 0 marks an infinite program since it never decrements from 0
  assign wrap = (loops_left_q != 8'd1);
`else
  logic unused_loop_cfg;
  assign unused_loop_cfg = ^cfg_loop_count;
  assign wrap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    last_d     = last_q;
    final_d    = final_q;
    pf_valid_d = pf_valid_q;
    pf_level_d = pf_level_q;
    pf_last_d  = pf_last_q;
    pf_dur_d   = pf_dur_q;
    level_d    = level_q;
    dur_d      = dur_q;
    loop_d     = 1'b0;
    done_d     = done_q & ~irq_clear;
`ifdef PULSE_SEQ_LOOP_EN
    loops_left_d = loops_left_q;
`endif

    case (state_q)
      S_IDLE: begin
        level_d = cfg_idle_level;
        if (start && !start_q) begin
          pc_d    = cfg_start_pc;
          final_d = 1'b0;
`ifdef PULSE_SEQ_LOOP_EN
          loops_left_d = cfg_loop_count;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        last_d  = cur_last;
        level_d = cur_sym[1];
        dur_d   = cur_dur;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pf_valid_d = 1'b0;
        state_d    = S_WAIT;
        if (!last_q) begin
          pc_d = pc_q + 1'b1;
        end else if (wrap) begin
          pc_d   = cfg_start_pc;
          loop_d = 1'b1;
`ifdef PULSE_SEQ_LOOP_EN
          if (loops_left_q != 8'd0) loops_left_d = loops_left_q - 8'd1;
`endif
        end else begin
          final_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!pf_valid_q && !final_q) begin
          pf_level_d = cur_sym[1];
          pf_dur_d   = cur_dur;
          pf_last_d  = cur_last;
          pf_valid_d = 1'b1;
        end
        if (tmr_done) begin
          if (final_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            level_d = cfg_idle_level;
          end else begin
            // timer may finish before the prefetch slot has been used; read memory directly then
            state_d = S_ISSUE;
            level_d = pf_valid_q ? pf_level_q : cur_sym[1];
            dur_d   = pf_valid_q ? pf_dur_q   : cur_dur;
            last_d  = pf_valid_q ? pf_last_q  : cur_last;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !start) begin
      state_d = S_IDLE;
      level_d = cfg_idle_level;
      loop_d  = 1'b0;
      done_d  = done_q & ~irq_clear;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      pc_q       <= '0;
      last_q     <= 1'b0;
      final_q    <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_level_q <= 1'b0;
      pf_last_q  <= 1'b0;
      pf_dur_q   <= '0;
      level_q    <= 1'b0;
      dur_q      <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PULSE_SEQ_LOOP_EN
      loops_left_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      pc_q       <= pc_d;
      last_q     <= last_d;
      final_q    <= final_d;
      pf_valid_q <= pf_valid_d;
      pf_level_q <= pf_level_d;
      pf_last_q  <= pf_last_d;
      pf_dur_q   <= pf_dur_d;
      level_q    <= level_d;
      dur_q      <= dur_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
`ifdef PULSE_SEQ_LOOP_EN
      loops_left_q <= loops_left_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign tmr_en       = busy;
  assign tmr_load     = (state_q == S_ISSUE);
  assign tmr_duration = dur_q;
  assign level_out    = level_q;
  assign loop_pulse   = loop_q;
  assign done_irq     = done_q;
  assign mem_addr     = pc_q[PC_W-1:4];

endmodule
